// File: rtl/turn_sequencer_pkg.sv
// Shared Connect-4 definitions: FSM state encoding, winner-detector status codes
// and board geometry used by the turn sequencer and its interface.
package connect4_pkg;

    localparam int N_COLS  = 4;
    localparam int N_ROWS  = 4;
    localparam int N_CELLS = N_COLS * N_ROWS;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        PLACE = 3'd2,
        EVAL  = 3'd3,
        OVER  = 3'd4
    } state_t;

    typedef logic [1:0] status_t;

    localparam status_t ONGOING = 2'b00;
    localparam status_t P0_WIN  = 2'b01;
    localparam status_t P1_WIN  = 2'b10;
    localparam status_t DRAW    = 2'b11;

    // 11 from the detector is not a result; only the two win codes end the game.
    function automatic logic is_win(input status_t s);
        return (s == P0_WIN) || (s == P1_WIN);
    endfunction

endpackage

// File: rtl/turn_sequencer_if.sv
// Player/detector-facing signal bundle of the turn sequencer; the sequencer
// takes the slave side, the environment (buttons, detector) the master side.
interface turn_sequencer_if;
    import connect4_pkg::*;

    logic                 btn;
    logic [N_COLS-1:0]    col_sel;
    status_t              game_status;
    logic                 eval_done;
    logic                 eval_req;
    logic [N_CELLS-1:0]   gameboard;
    logic [N_CELLS-1:0]   player_cells;
    logic                 player;
    status_t              final_status;
    logic                 reject_pulse;
    logic                 timeout_pulse;

    modport master (
        output btn, col_sel, game_status, eval_done,
        input  eval_req, gameboard, player_cells, player, final_status,
               reject_pulse, timeout_pulse
    );

    modport slave (
        input  btn, col_sel, game_status, eval_done,
        output eval_req, gameboard, player_cells, player, final_status,
               reject_pulse, timeout_pulse
    );

endinterface

// File: rtl/turn_sequencer_press_edge.sv
// Turns the raw drop-piece button level into a registered one-cycle press pulse
// on each 0->1 transition; a held button yields a single pulse.
module press_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);

    logic btn_q;
    logic press_q;

    // Remember the previous level and flag a rising transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q   <= 1'b0;
            press_q <= 1'b0;
        end else begin
            btn_q   <= btn_i;
            press_q <= btn_i & ~btn_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/turn_sequencer.sv
// Connect-4 turn sequencer: accepts a column press, validates it, drops the piece,
// asks the winner detector to evaluate and advances the turn or ends the game.
// Optional MOVE_TIMEOUT_EN forfeits a turn after TIMEOUT_CYCLES idle cycles.
module turn_sequencer
    import connect4_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50
) (
    input  logic            clk,
    input  logic            reset,
    turn_sequencer_if.slave bus
);

    state_t               state_q;
    logic [N_COLS-1:0]    col_sel_q;
    logic [2:0]           height_q [N_COLS];
    logic [4:0]           moves_q;
    logic [N_CELLS-1:0]   board_q;
    logic [N_CELLS-1:0]   cells_q;
    logic                 player_q;
    status_t              final_q;
    logic                 eval_req_q;
    logic                 reject_q;

    logic                 press_s;
    logic                 col_ok_s;
    logic [1:0]           col_idx_s;
    logic [2:0]           col_h_s;
    logic [3:0]           cell_idx_s;
    logic [2:0]           height_d;
    logic [4:0]           moves_d;

`ifdef MOVE_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0]      to_cnt_q;
    logic                 timeout_q;
`endif

    press_edge u_press_edge (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (bus.btn),
        .press_o (press_s)
    );

    // Decode the latched column selection and the target cell of the move.
    always_comb begin
        col_ok_s  = 1'b1;
        col_idx_s = 2'd0;
        case (col_sel_q)
            4'b0001: col_idx_s = 2'd0;
            4'b0010: col_idx_s = 2'd1;
            4'b0100: col_idx_s = 2'd2;
            4'b1000: col_idx_s = 2'd3;
            default: col_ok_s  = 1'b0;
        endcase
        col_h_s    = height_q[col_idx_s];
        cell_idx_s = {col_idx_s, col_h_s[1:0]};
        height_d   = col_h_s + 3'd1;
        moves_d    = moves_q + 5'd1;
    end

    // Turn FSM together with the board, per-column heights and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            col_sel_q  <= 4'b0000;
            for (int c = 0; c < N_COLS; c++) begin
                height_q[c] <= 3'd0;
            end
            moves_q    <= 5'd0;
            board_q    <= 16'h0000;
            cells_q    <= 16'h0000;
            player_q   <= 1'b0;
            final_q    <= ONGOING;
            eval_req_q <= 1'b0;
            reject_q   <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
            to_cnt_q   <= {TO_W{1'b0}};
            timeout_q  <= 1'b0;
`endif
        end else begin
            reject_q  <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (press_s) begin
                        col_sel_q <= bus.col_sel;
                        state_q   <= CHECK;
`ifdef MOVE_TIMEOUT_EN
                        to_cnt_q  <= {TO_W{1'b0}};
                    end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        player_q  <= ~player_q;
                        timeout_q <= 1'b1;
                        to_cnt_q  <= {TO_W{1'b0}};
                    end else begin
                        to_cnt_q  <= to_cnt_q + TO_W'(1);
`endif
                    end
                end
                CHECK: begin
                    if (col_ok_s && (col_h_s != 3'd4)) begin
                        state_q  <= PLACE;
                    end else begin
                        reject_q <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                PLACE: begin
                    board_q[cell_idx_s]  <= 1'b1;
                    cells_q[cell_idx_s]  <= player_q;
                    height_q[col_idx_s]  <= height_d;
                    moves_q              <= moves_d;
                    eval_req_q           <= 1'b1;
                    state_q              <= EVAL;
                end
                EVAL: begin
                    if (bus.eval_done) begin
                        eval_req_q <= 1'b0;
                        if (is_win(bus.game_status)) begin
                            final_q <= bus.game_status;
                            state_q <= OVER;
                        end else if (moves_q == 5'd16) begin
                            final_q <= DRAW;
                            state_q <= OVER;
                        end else begin
                            player_q <= ~player_q;
                            state_q  <= IDLE;
                        end
                    end
                end
                OVER: begin
                    state_q <= OVER;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.eval_req     = eval_req_q;
    assign bus.gameboard    = board_q;
    assign bus.player_cells = cells_q;
    assign bus.player       = player_q;
    assign bus.final_status = final_q;
    assign bus.reject_pulse = reject_q;

`ifdef MOVE_TIMEOUT_EN
    assign bus.timeout_pulse = timeout_q;
`else
    logic timeout_unused_s;
    assign timeout_unused_s  = (TIMEOUT_CYCLES == 0);
    assign bus.timeout_pulse = 1'b0;
`endif

endmodule

// File: doc/turn_sequencer.md
TURN_SEQUENCER -- requirements
Module: turn_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50, idle cycles before a turn is forfeited (used only with MOVE_TIMEOUT_EN).
REQ-002 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port btn, input, 1, raw drop-piece button level.
REQ-005 SHALL have port col_sel, input, 4, column switches; must be one-hot.
REQ-006 SHALL have port game_status, input, 2, winner-detector result: 00 ongoing, 01 P0 win, 10 P1 win.
REQ-007 SHALL have port eval_done, input, 1, detector result-valid strobe.
REQ-008 SHALL have port eval_req, output, 1, request to the detector to evaluate the board.
REQ-009 SHALL have port gameboard, output, 16, occupied-cell map; cell index = col*4 + row, row 0 = bottom.
REQ-010 SHALL have port player_cells, output, 16, owner per cell: 0 = P0, 1 = P1.
REQ-011 SHALL have port player, output, 1, player whose turn it is.
REQ-012 SHALL have port final_status, output, 2, 00 ongoing, 01 P0 win, 10 P1 win, 11 draw.
REQ-013 SHALL have port reject_pulse, output, 1, one-cycle pulse when a press is refused.
REQ-014 SHALL have port timeout_pulse, output, 1, one-cycle pulse when a turn is forfeited.

Function
REQ-015 SHALL implement states IDLE, CHECK, PLACE, EVAL, OVER.
REQ-016 SHALL convert btn to a one-cycle press pulse on its 0->1 transition (registered; btn held high gives one pulse).
REQ-017 SHALL accept a press only in IDLE; presses in all other states are dropped silently.
REQ-018 SHALL in CHECK refuse the move (reject_pulse, return to IDLE, no board change) if col_sel is not one-hot or the selected column height equals 4.
REQ-019 SHALL latch the selected column index in IDLE on the accepted press; col_sel changes afterwards have no effect on that move.
REQ-020 SHALL in PLACE set gameboard[col*4+height] = 1, set player_cells at that index to player, and increment the column height and the 5-bit move count, in one cycle.
REQ-021 SHALL have fixed latency: press accepted in cycle T, board bits visible at T+3, eval_req high from T+3.
REQ-022 SHALL hold eval_req high in EVAL until eval_done is sampled high, then drop it on the next cycle.
REQ-023 SHALL on eval_done with game_status != 00 copy game_status to final_status and enter OVER.
REQ-024 SHALL on eval_done with game_status == 00 and move count == 16 set final_status = 11 and enter OVER.
REQ-025 SHALL otherwise toggle player and return to IDLE.
REQ-026 SHALL treat game_status == 11 as ongoing.
REQ-027 SHALL in OVER hold board, player and final_status until reset.

Reset
REQ-028 SHALL on reset set state IDLE, gameboard = 0, player_cells = 0, player = 0, final_status = 00, all column heights and the move count to 0, and all pulses and eval_req to 0.
REQ-029 SHALL give reset priority over every event, including reset coinciding with eval_done or a press.

Configuration
REQ-030 SHALL, with MOVE_TIMEOUT_EN defined, count consecutive IDLE cycles and, at TIMEOUT_CYCLES, toggle player, pulse timeout_pulse and clear the count.
REQ-031 SHALL clear the count on any accepted press and on leaving IDLE; a press and expiry in the same cycle SHALL resolve as the press.
REQ-032 SHALL, without MOVE_TIMEOUT_EN, contain no timeout counter and tie timeout_pulse to 0.

Structure
REQ-033 SHALL place the state encoding, status codes (ONGOING, P0_WIN, P1_WIN, DRAW), N_COLS = 4 and N_ROWS = 4 in shared package connect4_pkg.
REQ-034 SHALL implement the button rising-edge pulse in sub-module press_edge.

Verification
REQ-035 SHALL verify: after reset, press with col_sel = 0001 -> gameboard = 0x0001, player_cells = 0x0000, eval_req at T+3; eval_done with status 00 -> player = 1.
REQ-036 SHALL verify: five presses on col_sel = 0010 with eval_done = 00 each time -> 4 placed (gameboard = 0x00F0, player_cells = 0x00A0); 5th gives reject_pulse and no change.
REQ-037 SHALL verify: col_sel = 0011 or 0000 -> reject_pulse, board unchanged, player unchanged.
REQ-038 SHALL verify: eval_done with game_status = 10 -> final_status = 10, OVER; further presses leave the board unchanged until reset.
REQ-039 SHALL verify: 16 accepted moves, all evaluated 00 -> final_status = 11.
REQ-040 SHALL verify, with MOVE_TIMEOUT_EN and TIMEOUT_CYCLES = 8: no press for 8 IDLE cycles -> timeout_pulse and player toggled; reset asserted during EVAL -> all outputs zero on the next cycle.
